gpr_bank: RTL and testbench
===========================

Name: gpr_bank

Overview:
Parametrised successor to the general purpose register file: a REG_N x DATA_W register array with one write port and a registered read path.
- Single-read mode returns one register on the next cycle.
- Sum mode adds OPS_N register operands over OPS_N cycles with a busy/valid handshake and overflow detection.
- Sits between the CPU control unit and the ALU operand path. Read-side outputs are registered.

Parameters:
DATA_W, 14, register and data width in bits
ADDR_W, 12, width of the address bus
REG_N, 16, number of registers; must equal 2**REG_W
REG_W, 4, width of one register-index field
OPS_N, 3, operand count in sum mode; requires OPS_N*REG_W <= ADDR_W and OPS_N >= 1

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
address  input  ADDR_W  write index in [REG_W-1:0]; read field k in [ADDR_W-1-k*REG_W -: REG_W], k=0..OPS_N-1
data_in  input  DATA_W  write data
GPR_wr  input  1  write strobe
GPR_rd  input  1  read/sum request strobe
mode  input  1  0 = single read of field 0; 1 = sum of fields 0..OPS_N-1
data_out  output  DATA_W  registered result
valid  output  1  one-cycle pulse when data_out is updated
busy  output  1  high while a sum is in progress
overflow  output  1  carry lost in the last completed sum; 0 after a single read

Behaviour:
- Reset (rst=1 at an edge) clears the following: all registers, data_out, valid, busy, overflow, operand counter and the latched address. The FSM goes to IDLE. Reset overrides write and read in the same cycle.
- Write: when GPR_wr=1 at an edge, registers[address[REG_W-1:0]] <= data_in. Writes are accepted in every state, including while busy.
- Read-before-write: a read at the same edge as a write to that register returns the old value.
- FSM states: IDLE and ACC.
- IDLE, GPR_rd=1, mode=0:
  - Next edge: data_out <= reg[field0], valid=1, overflow=0.
  - Latency is 1 cycle. Back-to-back reads are allowed every cycle.
- IDLE, GPR_rd=1, mode=1:
  - Latch address and clear the accumulator. Set busy=1, k=0, go to ACC.
  - The request edge is t.
- ACC:
  - At each edge t+1..t+OPS_N, add reg[field k] (value at that edge, read-first) to the accumulator; k++.
  - Accumulator is DATA_W+clog2(OPS_N) bits wide.
  - At edge t+OPS_N:
    - data_out <= accumulator[DATA_W-1:0].
    - overflow <= |upper bits.
    - valid=1, busy=0, go to IDLE.
  - A new request may be accepted at edge t+OPS_N+1 onward; valid is high during the cycle after edge t+OPS_N.
- OPS_N=1: a sum behaves like a single read, with 1 extra cycle of latency.
- GPR_rd while busy is ignored: no queuing and no error. mode is sampled only at acceptance.
- data_out holds its value between results. valid is low in every cycle except the completion cycle.
- Arithmetic is unsigned modulo 2**DATA_W.
- Reset mid-sum aborts the sum: no valid pulse, data_out=0.

Decomposition:
- Package gpr_pkg holds:
  - the state encoding (IDLE, ACC);
  - register index constants AX=0, BX=1, CX=2, DX=3, SI=4, DI=5, BP=6, SP=7, AX1..AX8=8..15;
  - a function field_idx(address, k) that extracts read field k.
- One sub-module, gpr_array: storage only.
  - Synchronous write port and one combinational read port.
  - gpr_bank instantiates it and holds the FSM, accumulator and output registers.

Test Plan:
1. Reset, then single read of every index with mode=0 -> data_out=0, valid pulses one cycle after each GPR_rd, busy stays 0.
2. Write 100, 200 and 300 to regs 1, 2 and 3; GPR_rd, mode=1, address=12'h123 -> busy for 3 cycles, then data_out=600, valid=1 for one cycle, overflow=0.
3. Write 14'h3FFF to regs 1, 2 and 3; sum address 12'h123 -> data_out=14'h3FFD, overflow=1. A following single read of reg 1 -> data_out=14'h3FFF, overflow=0.
4. Write data 55 at address 12'hAB5 -> reg 5=55 and regs 10 and 11 unchanged. Single read at address 12'h5xx -> data_out=55.
5. Sum 12'h123 starting at edge t, with reg 3 rewritten to 1 at edge t+1 -> result 100+200+1=301. A GPR_rd issued while busy produces no extra valid pulse.
6. Assert rst at edge t+2 of a sum -> busy=0, valid never pulses, all registers read back 0 afterwards.

Source files
------------

// File: rtl/gpr_pkg.sv
// gpr_pkg: shared constants, state encoding and read-field extraction for gpr_bank
package gpr_pkg;
   localparam int DEF_DATA_W = 14;
   localparam int DEF_ADDR_W = 12;
   localparam int DEF_REG_N  = 16;
   localparam int DEF_REG_W  = 4;
   localparam int DEF_OPS_N  = 3;
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_ACC  = 1'b1;
   localparam logic [3:0] AX  = 4'd0;
   localparam logic [3:0] BX  = 4'd1;
   localparam logic [3:0] CX  = 4'd2;
   localparam logic [3:0] DX  = 4'd3;
   localparam logic [3:0] SI  = 4'd4;
   localparam logic [3:0] DI  = 4'd5;
   localparam logic [3:0] BP  = 4'd6;
   localparam logic [3:0] SP  = 4'd7;
   localparam logic [3:0] AX1 = 4'd8;
   localparam logic [3:0] AX2 = 4'd9;
   localparam logic [3:0] AX3 = 4'd10;
   localparam logic [3:0] AX4 = 4'd11;
   localparam logic [3:0] AX5 = 4'd12;
   localparam logic [3:0] AX6 = 4'd13;
   localparam logic [3:0] AX7 = 4'd14;
   localparam logic [3:0] AX8 = 4'd15;
   // Field 0 sits in the top REG_W bits of the address, field k just below field k-1.
   function automatic int unsigned field_idx(input logic [31:0] a, input int k, input int aw, input int rw);
      return (a >> (aw - rw * (k + 1))) & ((32'd1 << rw) - 32'd1);
   endfunction
endpackage

// File: rtl/gpr_bank_if.sv
// gpr_bank_if: request/write bus from the control unit and the registered result bus
interface gpr_bank_if #(
   parameter int DATA_W = 14,
   parameter int ADDR_W = 12
) ();
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data_in;
   logic              GPR_wr;
   logic              GPR_rd;
   logic              mode;
   logic [DATA_W-1:0] data_out;
   logic              valid;
   logic              busy;
   logic              overflow;
   modport master (output address, data_in, GPR_wr, GPR_rd, mode, input data_out, valid, busy, overflow);
   modport slave (input address, data_in, GPR_wr, GPR_rd, mode, output data_out, valid, busy, overflow);
endinterface

// File: rtl/gpr_array.sv
// gpr_array: REG_N x DATA_W storage, one synchronous write port, one combinational read port
module gpr_array import gpr_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_N  = DEF_REG_N,
   parameter int REG_W  = DEF_REG_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr,
   input  logic [REG_W-1:0]  i_wr_idx,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [REG_W-1:0]  i_rd_idx,
   output logic [DATA_W-1:0] o_rd_data
);
   logic [DATA_W-1:0] r_regs [REG_N];
   assign o_rd_data = r_regs[i_rd_idx];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_N; i++) r_regs[i] <= '0;
      end else if (i_wr) begin
         r_regs[i_wr_idx] <= i_wr_data;
      end
   end
endmodule

// File: rtl/gpr_bank.sv
// gpr_bank: register bank with single registered read and multi-cycle OPS_N-operand sum
module gpr_bank import gpr_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int REG_N  = DEF_REG_N,
   parameter int REG_W  = DEF_REG_W,
   parameter int OPS_N  = DEF_OPS_N
) (
   input logic       clk,
   input logic       rst,
   gpr_bank_if.slave bus
);
   localparam int K_W   = OPS_N > 1 ? $clog2(OPS_N) : 1;
   localparam int ACC_W = DATA_W + $clog2(OPS_N);
   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [K_W-1:0]    r_k;
   logic [ACC_W-1:0]  r_acc;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              r_ovf;
   logic [REG_W-1:0]  w_rd_idx;
   logic [DATA_W-1:0] w_rd_data;
   logic [ACC_W-1:0]  w_sum;
   logic              w_last;
   assign w_rd_idx = r_state == S_ACC
      ? REG_W'(field_idx(32'(r_addr), int'(r_k), ADDR_W, REG_W))
      : REG_W'(field_idx(32'(bus.address), 0, ADDR_W, REG_W));
   assign w_sum  = r_acc + ACC_W'(w_rd_data);
   assign w_last = r_k == K_W'(OPS_N - 1);
   gpr_array #(.DATA_W(DATA_W), .REG_N(REG_N), .REG_W(REG_W)) u_array (
      .clk       (clk),
      .rst       (rst),
      .i_wr      (bus.GPR_wr),
      .i_wr_idx  (bus.address[REG_W-1:0]),
      .i_wr_data (bus.data_in),
      .i_rd_idx  (w_rd_idx),
      .o_rd_data (w_rd_data)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_k     <= '0;
         r_acc   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (r_state == S_IDLE) begin
            if (bus.GPR_rd && !bus.mode) begin
               r_data  <= w_rd_data;
               r_valid <= 1'b1;
               r_ovf   <= 1'b0;
            end else if (bus.GPR_rd) begin
               r_addr  <= bus.address;
               r_acc   <= '0;
               r_k     <= '0;
               r_state <= S_ACC;
            end
         end else begin
            r_acc <= w_sum;
            r_k   <= r_k + 1'b1;
            if (w_last) begin
               r_data  <= w_sum[DATA_W-1:0];
               r_ovf   <= |(w_sum >> DATA_W);
               r_valid <= 1'b1;
               r_state <= S_IDLE;
            end
         end
      end
   end
   assign bus.data_out = r_data;
   assign bus.valid    = r_valid;
   assign bus.busy     = r_state == S_ACC;
   assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_gpr_bank.sv
// tb_gpr_bank: directed stimulus, per-cycle comparison against a behavioural bank model
module tb_gpr_bank;
   logic clk = 1'b0;
   logic rst;
   gpr_bank_if #(.DATA_W(14), .ADDR_W(12)) bus ();
   gpr_bank dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   logic [13:0] m_regs [16];
   logic [11:0] m_addr;
   logic [13:0] m_data;
   logic m_valid, m_ovf, m_busy;
   int m_left, m_total;
   bit started = 0;

   function automatic int fld(input logic [11:0] a, input int k);
      return int'((a >> (8 - 4 * k)) & 12'hF);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: a sum takes OPS_N edges after acceptance, each adding the register as it was before that edge's write.
   always @(posedge clk) begin
      started = 1;
      if (rst) begin
         for (int i = 0; i < 16; i++) m_regs[i] = '0;
         m_left = 0; m_total = 0; m_addr = '0;
         m_data = '0; m_valid = 0; m_ovf = 0;
      end else begin
         m_valid = 0;
         if (m_left > 0) begin
            m_total += int'(m_regs[fld(m_addr, 3 - m_left)]);
            m_left--;
            if (m_left == 0) begin
               m_data = 14'(m_total);
               m_ovf = m_total > 16383;
               m_valid = 1;
            end
         end else if (bus.GPR_rd && !bus.mode) begin
            m_data = m_regs[fld(bus.address, 0)];
            m_ovf = 0;
            m_valid = 1;
         end else if (bus.GPR_rd) begin
            m_addr = bus.address;
            m_total = 0;
            m_left = 3;
         end
         if (bus.GPR_wr) m_regs[bus.address[3:0]] = bus.data_in;
      end
      m_busy = m_left > 0;
   end

   always @(negedge clk) begin
      if (started) begin
         chk("model_valid", 32'(bus.valid), 32'(m_valid));
         chk("model_busy", 32'(bus.busy), 32'(m_busy));
         chk("model_data", 32'(bus.data_out), 32'(m_data));
         chk("model_ovf", 32'(bus.overflow), 32'(m_ovf));
      end
   end

   task automatic cyc(input bit r, input bit w, input bit rd, input bit md, input logic [11:0] a, input logic [13:0] d);
      rst = r; bus.GPR_wr = w; bus.GPR_rd = rd; bus.mode = md; bus.address = a; bus.data_in = d;
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 12'h000, 14'h0);
   endtask

   initial begin
      cyc(1, 0, 0, 0, 12'h000, 14'h0);
      cyc(1, 1, 1, 1, 12'h123, 14'h1);
      idle();
      chk("reset_data", 32'(bus.data_out), 0);
      chk("reset_valid", 32'(bus.valid), 0);
      chk("reset_busy", 32'(bus.busy), 0);
      chk("reset_ovf", 32'(bus.overflow), 0);
      for (int i = 0; i < 16; i++) begin
         cyc(0, 0, 1, 0, 12'(i << 8), 14'h0);
         chk("t1_valid", 32'(bus.valid), 1);
         chk("t1_data", 32'(bus.data_out), 0);
         chk("t1_busy", 32'(bus.busy), 0);
      end
      idle();
      chk("t1_valid_drop", 32'(bus.valid), 0);
      cyc(0, 1, 0, 0, 12'h001, 14'd100);
      cyc(0, 1, 0, 0, 12'h002, 14'd200);
      cyc(0, 1, 0, 0, 12'h003, 14'd300);
      cyc(0, 0, 1, 1, 12'h123, 14'h0);
      chk("t2_busy0", 32'(bus.busy), 1);
      for (int i = 0; i < 2; i++) begin
         idle();
         chk("t2_busy", 32'(bus.busy), 1);
         chk("t2_novalid", 32'(bus.valid), 0);
      end
      idle();
      chk("t2_valid", 32'(bus.valid), 1);
      chk("t2_data", 32'(bus.data_out), 600);
      chk("t2_ovf", 32'(bus.overflow), 0);
      chk("t2_busy_end", 32'(bus.busy), 0);
      idle();
      chk("t2_valid_drop", 32'(bus.valid), 0);
      chk("t2_hold", 32'(bus.data_out), 600);
      for (int i = 1; i <= 3; i++) cyc(0, 1, 0, 0, 12'(i), 14'h3FFF);
      cyc(0, 0, 1, 1, 12'h123, 14'h0);
      idle(); idle(); idle();
      chk("t3_data", 32'(bus.data_out), 32'h3FFD);
      chk("t3_ovf", 32'(bus.overflow), 1);
      cyc(0, 0, 1, 0, 12'h100, 14'h0);
      chk("t3_read", 32'(bus.data_out), 32'h3FFF);
      chk("t3_ovf_clr", 32'(bus.overflow), 0);
      cyc(0, 1, 0, 0, 12'hAB5, 14'd55);
      cyc(0, 0, 1, 0, 12'h5A7, 14'h0);
      chk("t4_reg5", 32'(bus.data_out), 55);
      cyc(0, 0, 1, 0, 12'hA00, 14'h0);
      chk("t4_reg10", 32'(bus.data_out), 0);
      cyc(0, 0, 1, 0, 12'hB00, 14'h0);
      chk("t4_reg11", 32'(bus.data_out), 0);
      for (int i = 1; i <= 3; i++) cyc(0, 1, 0, 0, 12'(i), 14'(i * 100));
      cyc(0, 0, 1, 1, 12'h123, 14'h0);
      cyc(0, 1, 1, 0, 12'h103, 14'd1);
      chk("t5_ignored1", 32'(bus.valid), 0);
      cyc(0, 0, 1, 0, 12'h100, 14'h0);
      chk("t5_ignored2", 32'(bus.valid), 0);
      idle();
      chk("t5_valid", 32'(bus.valid), 1);
      chk("t5_data", 32'(bus.data_out), 301);
      idle();
      chk("t5_no_extra", 32'(bus.valid), 0);
      cyc(0, 0, 1, 1, 12'h123, 14'h0);
      idle();
      cyc(1, 0, 0, 0, 12'h000, 14'h0);
      chk("t6_busy", 32'(bus.busy), 0);
      chk("t6_data", 32'(bus.data_out), 0);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("t6_novalid", 32'(bus.valid), 0);
      end
      for (int i = 0; i < 16; i++) begin
         cyc(0, 0, 1, 0, 12'(i << 8), 14'h0);
         chk("t6_cleared", 32'(bus.data_out), 0);
      end
      idle();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
